iic_axil_sequencer: RTL

- AXI4-Lite master that sequences register accesses to the AXI IIC core (9-bit address, 32-bit data) from a simple command stream.
- Supports single write, single read and poll-until-match with bounded retries, so IIC transactions can run without a processor (TX FIFO load, CR setup, SR polling).
- Sits between a command source (ROM or script FIFO) and the IIC core's s_axi slave port, in the same clk domain.

---
 rtl/iic_axil_sequencer_pkg.sv | 42 ++++
 rtl/iic_axil_sequencer_if.sv | 33 +++
 rtl/iic_axil_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/iic_axil_sequencer_pkg.sv
// Shared types and constants for the AXI-Lite IIC register sequencer.
// Command-script authors use the register offsets below to address the IIC core.
package iic_seq_pkg;

   // Command opcodes; encoding 2'd3 is reserved and answered with an error.
   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_POLL  = 2'd2
   } op_e;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_POLL_GAP_WAIT,
      ST_RSP
   } state_e;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // AXI IIC core register byte offsets
   localparam logic [8:0] REG_GIE     = 9'h01C;
   localparam logic [8:0] REG_ISR     = 9'h020;
   localparam logic [8:0] REG_SOFTR   = 9'h040;
   localparam logic [8:0] REG_CR      = 9'h100;
   localparam logic [8:0] REG_SR      = 9'h104;
   localparam logic [8:0] REG_TX_FIFO = 9'h108;
   localparam logic [8:0] REG_RX_FIFO = 9'h10C;

   // True for SLVERR or DECERR; EXOKAY never appears on AXI-Lite.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/iic_axil_sequencer_if.sv
// AXI4-Lite bus between the sequencer (master) and the IIC core (slave).
interface iic_axil_sequencer_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/iic_axil_sequencer.sv
// AXI4-Lite master that runs WRITE / READ / POLL commands against the IIC core,
// one AXI transaction at a time, returning one response per command.
module iic_axil_sequencer
   import iic_seq_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int POLL_GAP = 64,
   parameter int POLL_MAX = 1024
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [DATA_W-1:0] cmd_mask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   iic_axil_sequencer_if.master m_axi
);

   localparam int CNT_W  = $clog2(POLL_MAX + 1);
   localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int STRB_W = DATA_W / 8;

   logic [1:0]        r_rst_sync;
   logic              w_rst_n;

   state_e            r_state;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_mask;
   logic [CNT_W-1:0]  r_poll_cnt;
   logic [GAP_W-1:0]  r_gap_cnt;

   logic              r_cmd_ready;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_bready;
   logic              r_arvalid;
   logic              r_rready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic              r_rsp_timeout;

   logic              w_aw_ok;
   logic              w_w_ok;
   logic              w_rerr;
   logic              w_match;
   logic [CNT_W-1:0]  w_poll_cnt_inc;

   // Reset asserts asynchronously but releases only on a clock edge
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // An address/data channel counts as done once its valid has been dropped
   // or it is handshaking in this cycle.
   assign w_aw_ok        = !r_awvalid || m_axi.awready;
   assign w_w_ok         = !r_wvalid  || m_axi.wready;
   assign w_rerr         = resp_is_err(m_axi.rresp);
   assign w_match        = ((m_axi.rdata & r_mask) == (r_data & r_mask));
   assign w_poll_cnt_inc = r_poll_cnt + CNT_W'(1);

   // Sequencer FSM with all handshake outputs registered
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= ST_IDLE;
         r_op          <= 2'd0;
         r_addr        <= '0;
         r_data        <= '0;
         r_mask        <= '0;
         r_poll_cnt    <= '0;
         r_gap_cnt     <= '0;
         r_cmd_ready   <= 1'b0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready   <= 1'b0;
                  r_op          <= cmd_op;
                  r_addr        <= cmd_addr;
                  r_data        <= cmd_data;
                  r_mask        <= cmd_mask;
                  r_poll_cnt    <= '0;
                  r_rsp_data    <= '0;
                  r_rsp_err     <= 1'b0;
                  r_rsp_timeout <= 1'b0;
                  case (cmd_op)
                     OP_WRITE: begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_WR_REQ;
                     end
                     OP_READ, OP_POLL: begin
                        r_arvalid <= 1'b1;
                        r_state   <= ST_RD_REQ;
                     end
                     default: begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                     end
                  endcase
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            ST_WR_REQ: begin
               if (m_axi.awready) r_awvalid <= 1'b0;
               if (m_axi.wready)  r_wvalid  <= 1'b0;
               if (w_aw_ok && w_w_ok) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (m_axi.bvalid) begin
                  r_bready    <= 1'b0;
                  r_rsp_err   <= resp_is_err(m_axi.bresp);
                  r_rsp_data  <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end
            ST_RD_REQ: begin
               if (m_axi.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_RESP;
               end
            end
            ST_RD_RESP: begin
               if (m_axi.rvalid) begin
                  r_rready   <= 1'b0;
                  r_rsp_data <= m_axi.rdata;
                  if (r_op != OP_POLL) begin
                     r_rsp_err   <= w_rerr;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RSP;
                  end else begin
                     r_poll_cnt <= w_poll_cnt_inc;
                     if (w_rerr) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                     end else if (w_match) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                     end else if (w_poll_cnt_inc == CNT_W'(POLL_MAX)) begin
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RSP;
                     end else begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_POLL_GAP_WAIT;
                     end
                  end
               end
            end
            ST_POLL_GAP_WAIT: begin
               if (r_gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                  r_arvalid <= 1'b1;
                  r_state   <= ST_RD_REQ;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign busy          = (r_state != ST_IDLE);
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign rsp_err       = r_rsp_err;
   assign rsp_timeout   = r_rsp_timeout;

   assign m_axi.awaddr  = r_addr;
   assign m_axi.awvalid = r_awvalid;
   assign m_axi.wdata   = r_data;
   assign m_axi.wstrb   = r_mask[STRB_W-1:0];
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.bready  = r_bready;
   assign m_axi.araddr  = r_addr;
   assign m_axi.arvalid = r_arvalid;
   assign m_axi.rready  = r_rready;

endmodule
